vend_ctrl: RTL

Parametrised vending-machine controller, the next generation of the single-token drink FSM. It accumulates multi-denomination coin credit, supports NUM_SEL priced selections, and rejects under-funded selections. It returns change or refunds through a valid/ack handshake and times out an abandoned credit session. It sits between the coin acceptor and selection panel on one side and the dispenser and change hopper on the other.

---
 rtl/vend_pkg.sv | 39 +++
 rtl/vend_credit.sv | 53 +++++
 rtl/vend_ctrl.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/vend_pkg.sv
// Shared state type, default sizes and saturating-add helper for the vending controller.
// Latency: none; the package holds only types, constants and a combinational function.
// Backpressure: not applicable.
package vend_pkg;

  // Controller phases: waiting for money, holding credit, dispensing, returning money.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CREDIT   = 2'd1,
    DISPENSE = 2'd2,
    CHANGE   = 2'd3
  } state_t;

  localparam int DEF_CREDIT_W = 8;
  localparam int DEF_NUM_SEL  = 4;

  // Widest credit the helper below can handle.
  localparam int SAT_MAX_W = 32;

  // Saturating add at width w (w <= SAT_MAX_W). The low SAT_MAX_W bits hold
  // min(a+b, 2^w-1); the top bit is set when the true sum did not fit in w bits.
  function automatic logic [SAT_MAX_W:0] sat_add(
    input logic [SAT_MAX_W-1:0] a,
    input logic [SAT_MAX_W-1:0] b,
    input int                   w
  );
    logic [SAT_MAX_W:0] one;
    logic [SAT_MAX_W:0] sum;
    logic [SAT_MAX_W:0] lim;
    one = {{SAT_MAX_W{1'b0}}, 1'b1};
    sum = {1'b0, a} + {1'b0, b};
    lim = (one << w) - one;
    if (sum > lim) begin
      return {1'b1, lim[SAT_MAX_W-1:0]};
    end
    return {1'b0, sum[SAT_MAX_W-1:0]};
  endfunction

endpackage

// File: rtl/vend_credit.sv
// Credit register with load, saturating add, subtract and clear, plus the add-overflow flag.
// Latency: credit updates on the clk edge after the command; add_ovf is combinational.
// Backpressure: none; an add that would overflow is simply not applied.
module vend_credit import vend_pkg::*; #(
  parameter int CREDIT_W = DEF_CREDIT_W
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                clr,
  input  logic                load,
  input  logic [CREDIT_W-1:0] load_value,
  input  logic                sub,
  input  logic [CREDIT_W-1:0] sub_value,
  input  logic                add,
  input  logic [CREDIT_W-1:0] add_value,
  output logic [CREDIT_W-1:0] credit,
  output logic                add_ovf
);

  logic [SAT_MAX_W:0]  sat_res;
  logic [CREDIT_W-1:0] sum_val;
  logic [CREDIT_W:0]   diff;
  logic                unused_bits;

  // Next-value arithmetic, one bit wider than the credit so carry and borrow are visible.
  always_comb begin
    sat_res = sat_add(SAT_MAX_W'(credit), SAT_MAX_W'(add_value), CREDIT_W);
    add_ovf = sat_res[SAT_MAX_W];
    sum_val = sat_res[CREDIT_W-1:0];
    diff    = {1'b0, credit} - {1'b0, sub_value};
  end

  // The borrow never fires (price is checked before a purchase) and the
  // upper saturated bits are always zero at this width.
  assign unused_bits = ^{sat_res[SAT_MAX_W-1:0] >> CREDIT_W, diff[CREDIT_W]};

  // Credit register: clear beats load beats subtract beats add; an overflowing
  // add leaves the credit untouched so the coin can be handed back.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      credit <= '0;
    end else if (clr) begin
      credit <= '0;
    end else if (load) begin
      credit <= load_value;
    end else if (sub) begin
      credit <= diff[CREDIT_W-1:0];
    end else if (add && !add_ovf) begin
      credit <= sum_val;
    end
  end

endmodule

// File: rtl/vend_ctrl.sv
// Vending controller: coin credit, priced selections, change/refund handshake, idle timeout.
// Latency: every output is registered and reacts on the clk edge after its trigger.
// Backpressure: change is held on change_valid until change_ack; coins arriving when they cannot be absorbed get coin_reject.
module vend_ctrl import vend_pkg::*; #(
  parameter int                          CREDIT_W    = DEF_CREDIT_W,
  parameter int                          NUM_SEL     = DEF_NUM_SEL,
  parameter logic [NUM_SEL*CREDIT_W-1:0] PRICES      = {NUM_SEL{8'd100}},
  parameter int                          TIMEOUT_CYC = 1000
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       coin_valid,
  input  logic [CREDIT_W-1:0]        coin_value,
  input  logic                       cancel,
  input  logic                       sel_valid,
  input  logic [$clog2(NUM_SEL)-1:0] sel_idx,
  input  logic                       received,
  input  logic                       change_ack,
  output logic                       flash,
  output logic [NUM_SEL-1:0]         drink,
  output logic                       deny,
  output logic                       coin_reject,
  output logic                       change_valid,
  output logic [CREDIT_W-1:0]        change_amount,
  output logic [CREDIT_W-1:0]        credit
);

  localparam int SEL_W   = $clog2(NUM_SEL);
  // The timer only needs to count up to TIMEOUT_CYC-1: the edge that would
  // take it to TIMEOUT_CYC is the timeout itself.
  localparam int TIMER_W = $clog2(TIMEOUT_CYC);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYC - 1);
  localparam logic [TIMER_W-1:0] TIMER_ONE  = TIMER_W'(1);

  state_t              state;
  logic [TIMER_W-1:0]  timer;

  logic [CREDIT_W-1:0] price;
  logic [NUM_SEL-1:0]  sel_onehot;
  logic                sel_hit;

  logic                in_credit;
  logic                timeout_hit;
  logic                refund_now;
  logic                buy_now;
  logic                deny_now;
  logic                coin_try;
  logic                coin_take;
  logic                cr_load;
  logic                cr_clr;
  logic                add_ovf;

  // Decode the requested selection into its price and one-hot dispense vector;
  // sel_hit stays low for an index with no selection behind it.
  always_comb begin
    price      = '0;
    sel_onehot = '0;
    sel_hit    = 1'b0;
    for (int i = 0; i < NUM_SEL; i++) begin
      if (sel_idx == SEL_W'(i)) begin
        price         = PRICES[i*CREDIT_W +: CREDIT_W];
        sel_onehot[i] = 1'b1;
        sel_hit       = 1'b1;
      end
    end
  end

  // Resolve what happens this cycle: in CREDIT, cancel/timeout wins over a
  // purchase, which wins over a coin. A zero-value coin in CREDIT adds nothing
  // but still counts as accepted activity.
  always_comb begin
    in_credit   = (state == CREDIT);
    timeout_hit = in_credit && (timer == TIMER_LAST);
    refund_now  = in_credit && (cancel || timeout_hit);
    buy_now     = in_credit && !refund_now && sel_valid && sel_hit && (credit >= price);
    deny_now    = in_credit && !refund_now && sel_valid && !buy_now;
    coin_try    = in_credit && !refund_now && !buy_now && coin_valid;
    coin_take   = coin_try && !add_ovf;
    cr_load     = (state == IDLE) && coin_valid && (coin_value != '0);
    cr_clr      = refund_now || ((state == DISPENSE) && received);
  end

  vend_credit #(
    .CREDIT_W (CREDIT_W)
  ) u_credit (
    .clk        (clk),
    .resetn     (resetn),
    .clr        (cr_clr),
    .load       (cr_load),
    .load_value (coin_value),
    .sub        (buy_now),
    .sub_value  (price),
    .add        (coin_try),
    .add_value  (coin_value),
    .credit     (credit),
    .add_ovf    (add_ovf)
  );

  // Controller FSM with the idle timer and every registered output.
  // deny and coin_reject default low each cycle so they only ever pulse.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state         <= IDLE;
      timer         <= '0;
      flash         <= 1'b1;
      drink         <= '0;
      deny          <= 1'b0;
      coin_reject   <= 1'b0;
      change_valid  <= 1'b0;
      change_amount <= '0;
    end else begin
      deny        <= 1'b0;
      coin_reject <= 1'b0;
      timer       <= '0;
      case (state)
        IDLE: begin
          // Zero-value coins, selections and cancels are ignored here.
          if (cr_load) begin
            state <= CREDIT;
            flash <= 1'b0;
          end
        end
        CREDIT: begin
          deny <= deny_now;
          if (refund_now) begin
            // Full refund; a coin landing in the same cycle is handed back.
            change_amount <= credit;
            change_valid  <= 1'b1;
            coin_reject   <= coin_valid;
            state         <= CHANGE;
          end else if (buy_now) begin
            drink       <= sel_onehot;
            coin_reject <= coin_valid;
            state       <= DISPENSE;
          end else begin
            // Overflowing coins are returned; only an accepted coin restarts
            // the timer (a denied selection does not).
            coin_reject <= coin_try && add_ovf;
            if (!coin_take) begin
              timer <= timer + TIMER_ONE;
            end
          end
        end
        DISPENSE: begin
          coin_reject <= coin_valid;
          if (received) begin
            drink <= '0;
            if (credit != '0) begin
              change_amount <= credit;
              change_valid  <= 1'b1;
              state         <= CHANGE;
            end else begin
              state <= IDLE;
              flash <= 1'b1;
            end
          end
        end
        CHANGE: begin
          // change_amount stays put until the hopper takes it.
          coin_reject <= coin_valid;
          if (change_ack) begin
            change_valid <= 1'b0;
            state        <= IDLE;
            flash        <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
